// File: rtl/wishbone_target_ram_if.sv
// rtl/wishbone_target_ram_if.sv - Wishbone B4 pipelined bus bundle between initiator and target RAM
interface wishbone_target_ram_if #(
  parameter int AddressWidth = 16,
  parameter int DataWidth    = 32,
  parameter int SelWidth     = 4
);
  logic [AddressWidth-1:0] ADR_I;
  logic [DataWidth-1:0]    DAT_I;
  logic [DataWidth-1:0]    DAT_O;
  logic [SelWidth-1:0]     SEL_I;
  logic                    WE_I;
  logic                    CYC_I;
  logic                    STB_I;
  logic                    LOCK_I;
  logic                    ACK_O;
  logic                    ERR_O;
  logic                    RTY_O;
  logic                    STALL_O;

  modport master (
    output ADR_I, DAT_I, SEL_I, WE_I, CYC_I, STB_I, LOCK_I,
    input  DAT_O, ACK_O, ERR_O, RTY_O, STALL_O
  );

  modport slave (
    input  ADR_I, DAT_I, SEL_I, WE_I, CYC_I, STB_I, LOCK_I,
    output DAT_O, ACK_O, ERR_O, RTY_O, STALL_O
  );
endinterface

// File: rtl/wishbone_target_ram.sv
// rtl/wishbone_target_ram.sv - Wishbone B4 pipelined target backed by a word-addressed RAM
module wishbone_target_ram #(
  parameter int AddressWidth   = 16,
  parameter int DataWidth      = 32,
  parameter int SelGranularity = 8,
  parameter int SelWidth       = DataWidth / SelGranularity,
  parameter int Depth          = 256,
  parameter int Latency        = 2,
  parameter int WaitStates     = 0
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  wishbone_target_ram_if.slave wb
);
  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataWidth-1:0] mem [Depth];
  logic [DataWidth-1:0] pipe_dat [Latency];
  logic [Latency-1:0]   pipe_vld;
  logic [Latency-1:0]   pipe_err;
  logic [2:0]           wait_cnt;
  logic                 accept;
  logic                 in_range;
  logic [IdxW-1:0]      idx;
  logic [DataWidth-1:0] rd_word;
  logic                 unused_lock;

  assign unused_lock = wb.LOCK_I;

  assign wb.STALL_O = (wait_cnt != 3'd0);
  assign accept     = wb.CYC_I && wb.STB_I && !wb.STALL_O;
  // Full-width compare so upper address bits can never alias into the array.
  assign in_range   = {1'b0, wb.ADR_I} < (AddressWidth + 1)'(Depth);
  assign idx        = wb.ADR_I[IdxW-1:0];
  assign rd_word    = mem[idx];

  always_ff @(posedge CLK_I) begin
    if (RST_I && accept && in_range && wb.WE_I) begin
      for (int k = 0; k < SelWidth; k++) begin
        if (wb.SEL_I[k]) begin
          mem[idx][k*SelGranularity +: SelGranularity] <= wb.DAT_I[k*SelGranularity +: SelGranularity];
        end
      end
    end
  end

  // Dropping CYC_I aborts everything in flight; data stages need no clearing.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int i = 0; i < Latency; i++) begin
        pipe_dat[i] <= '0;
      end
    end else if (!wb.CYC_I) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      pipe_err[0] <= !in_range;
      pipe_dat[0] <= (in_range && !wb.WE_I) ? rd_word : '0;
      for (int i = 1; i < Latency; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wait_cnt <= 3'd0;
    end else if (!wb.CYC_I) begin
      wait_cnt <= 3'd0;
    end else if (accept && (WaitStates > 0)) begin
      wait_cnt <= 3'(WaitStates);
    end else if (wait_cnt != 3'd0) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Terminations are qualified by CYC_I so an aborted cycle never sees a late response.
  assign wb.ACK_O = wb.CYC_I && pipe_vld[Latency-1] && !pipe_err[Latency-1];
  assign wb.ERR_O = wb.CYC_I && pipe_vld[Latency-1] && pipe_err[Latency-1];
  assign wb.DAT_O = wb.ACK_O ? pipe_dat[Latency-1] : '0;
  assign wb.RTY_O = 1'b0;
endmodule

// File: tb/tb_wishbone_target_ram.sv
// tb/tb_wishbone_target_ram.sv - scoreboard bench for wishbone_target_ram
module tb_wishbone_target_ram;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_ack = 0;
  int   n_err = 0;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model [16];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  wishbone_target_ram_if #(.AddressWidth(16), .DataWidth(32), .SelWidth(4)) bus_a ();
  wishbone_target_ram_if #(.AddressWidth(16), .DataWidth(32), .SelWidth(4)) bus_b ();

  wishbone_target_ram #(.Depth(16), .Latency(2), .WaitStates(0)) dut_a (
    .CLK_I(clk), .RST_I(rst_n), .wb(bus_a.slave));
  wishbone_target_ram #(.Depth(16), .Latency(1), .WaitStates(2)) dut_b (
    .CLK_I(clk), .RST_I(rst_n), .wb(bus_b.slave));

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (!bus_a.CYC_I) sb_q.delete();
      checks++;
      if (bus_a.ACK_O === 1'b1 && bus_a.ERR_O === 1'b1) begin
        errors++;
        $display("FAIL ack_err_overlap ack=%0b err=%0b required never both", bus_a.ACK_O, bus_a.ERR_O);
      end
      if (bus_a.ACK_O !== 1'b1) begin
        checks++;
        if (bus_a.DAT_O !== 32'h0) begin
          errors++;
          $display("FAIL dat_idle cycle=%0d got=%h required=00000000", cycle, bus_a.DAT_O);
        end
      end
      while (sb_q.size() > 0 && sb_q[0].due < cycle) begin
        checks++;
        errors++;
        $display("FAIL missing_response due=%0d now=%0d got none", sb_q[0].due, cycle);
        void'(sb_q.pop_front());
      end
      if (bus_a.ACK_O === 1'b1 || bus_a.ERR_O === 1'b1) begin
        if (bus_a.ACK_O === 1'b1) n_ack++;
        if (bus_a.ERR_O === 1'b1) n_err++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_response cycle=%0d ack=%0b err=%0b required none", cycle, bus_a.ACK_O, bus_a.ERR_O);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.due != cycle || mon_e.err !== bus_a.ERR_O || (mon_e.chk && bus_a.DAT_O !== mon_e.data)) begin
            errors++;
            $display("FAIL response cycle=%0d err=%0b dat=%h required cycle=%0d err=%0b dat=%h",
                     cycle, bus_a.ERR_O, bus_a.DAT_O, mon_e.due, mon_e.err, mon_e.data);
          end
        end
      end
      if (bus_a.CYC_I && bus_a.STB_I && !bus_a.STALL_O) begin
        mon_e.due = cycle + 2;
        mon_e.err = (bus_a.ADR_I >= 16'd16);
        mon_e.chk = !mon_e.err && !bus_a.WE_I;
        mon_e.data = 32'h0;
        if (!mon_e.err) begin
          mon_e.data = model[bus_a.ADR_I[3:0]];
          if (bus_a.WE_I) begin
            for (int k = 0; k < 4; k++) begin
              if (bus_a.SEL_I[k]) model[bus_a.ADR_I[3:0]][k*8 +: 8] = bus_a.DAT_I[k*8 +: 8];
            end
          end
        end
        sb_q.push_back(mon_e);
      end
    end
  end

  task automatic req_a(input logic we, input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus_a.WE_I  = we;
    bus_a.ADR_I = adr;
    bus_a.DAT_I = dat;
    bus_a.SEL_I = sel;
    bus_a.STB_I = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle_a(input int n);
    bus_a.STB_I = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus_a.ACK_O !== 1'b0 || bus_a.ERR_O !== 1'b0 || bus_a.STALL_O !== 1'b0 || bus_a.DAT_O !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b err=%b stall=%b dat=%h required all 0",
               bus_a.ACK_O, bus_a.ERR_O, bus_a.STALL_O, bus_a.DAT_O);
    end
    checks++;
    if (bus_b.STALL_O !== 1'b0 || bus_b.ACK_O !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_b stall=%b ack=%b required 0 0", bus_b.STALL_O, bus_b.ACK_O);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_a.CYC_I = 1'b1;
    idle_a(2);
  endtask

  task automatic test_write_read();
    int a0 = n_ack;
    int e0 = n_err;
    req_a(1'b1, 16'd3, 32'hDEADBEEF, 4'b1111);
    req_a(1'b0, 16'd3, 32'h0, 4'b0000);
    bus_a.STB_I = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus_a.ACK_O !== 1'b1 || bus_a.DAT_O !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read ack=%b dat=%h required ack=1 dat=deadbeef", bus_a.ACK_O, bus_a.DAT_O);
    end
    @(posedge clk); #1;
    idle_a(3);
    checks++;
    if (n_ack - a0 != 2 || n_err != e0) begin
      errors++;
      $display("FAIL write_read_count acks=%0d errs=%0d required 2 0", n_ack - a0, n_err - e0);
    end
  endtask

  task automatic test_byte_lanes();
    int a0 = n_ack;
    req_a(1'b1, 16'd5, 32'h11223344, 4'b1111);
    req_a(1'b1, 16'd5, 32'hAABBCCDD, 4'b0101);
    req_a(1'b0, 16'd5, 32'h0, 4'b0000);
    bus_a.STB_I = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus_a.ACK_O !== 1'b1 || bus_a.DAT_O !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_lanes ack=%b dat=%h required ack=1 dat=11bb33dd", bus_a.ACK_O, bus_a.DAT_O);
    end
    @(posedge clk); #1;
    idle_a(3);
    checks++;
    if (n_ack - a0 != 3) begin
      errors++;
      $display("FAIL byte_lanes_count acks=%0d required 3", n_ack - a0);
    end
  endtask

  task automatic test_out_of_range();
    int a0 = n_ack;
    int e0 = n_err;
    req_a(1'b1, 16'd0, 32'h12345678, 4'b1111);
    req_a(1'b0, 16'd16, 32'h0, 4'b0000);
    req_a(1'b1, 16'hFFFF, 32'hCAFEF00D, 4'b1111);
    req_a(1'b0, 16'd0, 32'h0, 4'b0000);
    bus_a.STB_I = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus_a.ACK_O !== 1'b1 || bus_a.DAT_O !== 32'h12345678) begin
      errors++;
      $display("FAIL oor_no_alias ack=%b dat=%h required ack=1 dat=12345678", bus_a.ACK_O, bus_a.DAT_O);
    end
    @(posedge clk); #1;
    idle_a(3);
    checks++;
    if (n_ack - a0 != 2 || n_err - e0 != 2) begin
      errors++;
      $display("FAIL oor_count acks=%0d errs=%0d required 2 2", n_ack - a0, n_err - e0);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    for (int i = 0; i < 4; i++) req_a(1'b1, 16'(i), 32'h10000000 + 32'h01010101 * i, 4'b1111);
    idle_a(3);
    a0 = n_ack;
    for (int i = 0; i < 4; i++) req_a(1'b0, 16'(i), 32'h0, 4'b0000);
    idle_a(4);
    checks++;
    if (n_ack - a0 != 4) begin
      errors++;
      $display("FAIL back_to_back_count acks=%0d required 4", n_ack - a0);
    end
  endtask

  task automatic test_abort();
    int a0 = n_ack;
    int e0 = n_err;
    req_a(1'b0, 16'd0, 32'h0, 4'b0000);
    req_a(1'b0, 16'd1, 32'h0, 4'b0000);
    bus_a.STB_I = 1'b0;
    bus_a.CYC_I = 1'b0;
    @(posedge clk); #1;
    bus_a.CYC_I = 1'b1;
    idle_a(4);
    checks++;
    if (n_ack != a0 || n_err != e0) begin
      errors++;
      $display("FAIL abort acks=%0d errs=%0d required 0 0", n_ack - a0, n_err - e0);
    end
  endtask

  task automatic test_reset_midburst();
    int a0 = n_ack;
    req_a(1'b0, 16'd1, 32'h0, 4'b0000);
    req_a(1'b0, 16'd2, 32'h0, 4'b0000);
    bus_a.STB_I = 1'b0;
    checks++;
    if (bus_a.ACK_O !== 1'b1) begin
      errors++;
      $display("FAIL midburst_inflight ack=%b required 1", bus_a.ACK_O);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.ACK_O !== 1'b0 || bus_a.ERR_O !== 1'b0 || bus_a.STALL_O !== 1'b0) begin
      errors++;
      $display("FAIL async_reset ack=%b err=%b stall=%b required 0 0 0", bus_a.ACK_O, bus_a.ERR_O, bus_a.STALL_O);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_a(5);
    checks++;
    if (n_ack != a0) begin
      errors++;
      $display("FAIL stale_ack acks=%0d required 0", n_ack - a0);
    end
  endtask

  task automatic test_wait_states();
    int   exp_stall[7] = '{0, 1, 1, 0, 1, 1, 0};
    int   acc_cyc[3] = '{-1, -1, -1};
    int   acc = 0;
    logic exp_ack;
    @(posedge clk); #1;
    bus_b.CYC_I = 1'b1;
    bus_b.STB_I = 1'b1;
    bus_b.WE_I  = 1'b1;
    bus_b.SEL_I = 4'hF;
    bus_b.ADR_I = 16'd0;
    bus_b.DAT_I = 32'h5000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 7) begin
        checks++;
        if (bus_b.STALL_O !== 1'(exp_stall[c])) begin
          errors++;
          $display("FAIL wait_stall c=%0d got=%b required=%0d", c, bus_b.STALL_O, exp_stall[c]);
        end
      end
      exp_ack = (c == 1 || c == 4 || c == 7);
      checks++;
      if (bus_b.ACK_O !== exp_ack || bus_b.ERR_O !== 1'b0) begin
        errors++;
        $display("FAIL wait_ack c=%0d ack=%b err=%b required ack=%b err=0", c, bus_b.ACK_O, bus_b.ERR_O, exp_ack);
      end
      if (bus_b.STB_I && !bus_b.STALL_O) begin
        if (acc < 3) acc_cyc[acc] = c;
        acc++;
      end
      @(posedge clk); #1;
      if (acc >= 3) begin
        bus_b.STB_I = 1'b0;
      end else begin
        bus_b.ADR_I = 16'(acc);
        bus_b.DAT_I = 32'h5000 + 32'(acc);
      end
    end
    checks++;
    if (acc != 3 || acc_cyc[0] != 0 || acc_cyc[1] != 3 || acc_cyc[2] != 6) begin
      errors++;
      $display("FAIL wait_accepts n=%0d at %0d,%0d,%0d required 3 at 0,3,6", acc, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    end
    bus_b.CYC_I = 1'b0;
  endtask

  initial begin
    bus_a.ADR_I = '0; bus_a.DAT_I = '0; bus_a.SEL_I = '0; bus_a.WE_I = 1'b0;
    bus_a.CYC_I = 1'b0; bus_a.STB_I = 1'b0; bus_a.LOCK_I = 1'b0;
    bus_b.ADR_I = '0; bus_b.DAT_I = '0; bus_b.SEL_I = '0; bus_b.WE_I = 1'b0;
    bus_b.CYC_I = 1'b0; bus_b.STB_I = 1'b0; bus_b.LOCK_I = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_back_to_back();
    test_abort();
    test_reset_midburst();
    test_wait_states();
    idle_a(3);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected n=%0d required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d required completion", cycle);
    $fatal(1);
  end
endmodule

// File: doc/wishbone_target_ram.md
Name: wishbone_target_ram

Overview:
- Wishbone B4 pipelined target (responder) backed by an internal word-addressed RAM.
- Sits on a target port of the team's Wishbone crossbar; it is the responder end of the same bus.
- Serves as the default memory/test target for crossbar bring-up.
- Configurable response latency and wait-state (STALL) injection exercise crossbar flow control.

Parameters:
- AddressWidth, 16, width of ADR_I; word address.
- DataWidth, 32, bits per data word.
- SelGranularity, 8, bits per SEL_I lane; DataWidth must be a multiple of it.
- SelWidth, DataWidth/SelGranularity, number of SEL_I lanes.
- Depth, 256, number of RAM words; must be at most 2^AddressWidth.
- Latency, 2, cycles from request acceptance to ACK_O/ERR_O; legal range 1..4.
- WaitStates, 0, cycles STALL_O is held high after each accepted request; legal range 0..7.

Ports:
- CLK_I  input  1  sole clock; all logic on rising edge.
- RST_I  input  1  reset, asynchronous assert, active-low.
- ADR_I  input  AddressWidth  word address.
- DAT_I  input  DataWidth  write data.
- DAT_O  output  DataWidth  read data; valid only with ACK_O.
- SEL_I  input  SelWidth  byte-lane enables for writes.
- WE_I  input  1  1 = write, 0 = read.
- CYC_I  input  1  bus cycle active.
- STB_I  input  1  request strobe.
- LOCK_I  input  1  accepted; no effect on this target.
- ACK_O  output  1  normal termination.
- ERR_O  output  1  error termination (address out of range).
- RTY_O  output  1  constant 0.
- STALL_O  output  1  target cannot accept a request this cycle.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (RST_I low), immediate and asynchronous:
  - ACK_O = ERR_O = STALL_O = 0; DAT_O = 0.
  - Response pipeline valid bits and wait counter cleared.
  - RAM contents are not reset.
- Acceptance: a request is accepted on a rising edge where CYC_I && STB_I && !STALL_O.
- Write (WE_I=1, ADR_I < Depth):
  - Each lane k with SEL_I[k]=1 updates bits [k*SelGranularity +: SelGranularity] at the acceptance edge.
  - Lanes with SEL_I[k]=0 are unchanged.
- Read (WE_I=0, ADR_I < Depth): the word is captured at the acceptance edge.
  - A write accepted on an earlier edge is always visible.
  - SEL_I is ignored for reads; the full word is returned.
- Out of range (ADR_I >= Depth):
  - No RAM access.
  - Response is ERR_O instead of ACK_O; DAT_O = 0.
- Response pipeline:
  - Shift register of depth Latency holding {valid, err, data}.
  - A request accepted at edge N asserts ACK_O or ERR_O for exactly one cycle, beginning after edge N+Latency-1. With Latency=1 the response is visible the cycle after acceptance.
  - Responses are strictly in order, one per accepted request; ACK_O and ERR_O are never high together.
  - Back-to-back acceptance gives back-to-back responses, throughput 1 per cycle when WaitStates=0.
  - DAT_O is 0 whenever ACK_O is low.
- Wait states:
  - On each acceptance with WaitStates>0, the counter loads WaitStates.
  - STALL_O = (counter != 0); the counter decrements each cycle to 0.
  - With WaitStates=0, STALL_O stays 0 except as below.
- CYC_I deasserted:
  - All in-flight pipeline entries are invalidated on that edge; no ACK_O/ERR_O is emitted for them. This is the Wishbone abort rule.
  - Writes already performed at acceptance are not rolled back.
  - The wait counter clears.
- STB_I without CYC_I is ignored.
- Max outstanding requests = Latency; STALL_O never rises because of pipeline fullness.
- ADR_I bits above log2(Depth) participate in the range check; there is no aliasing.

Test Plan (DataWidth=32, SelGranularity=8, Depth=16, Latency=2, WaitStates=0 unless stated):
- Reset: drive RST_I low mid-burst with 2 requests in flight -> ACK_O/ERR_O/STALL_O drop to 0 immediately with no clock edge; no stale ACK after release.
- Write then read: write 0xDEADBEEF to addr 3 with SEL=4'b1111, then read addr 3 on the next cycle -> read ACK_O exactly 2 cycles after its acceptance, DAT_O=0xDEADBEEF.
- Byte lanes: addr 5 holds 0x11223344; write 0xAABBCCDD with SEL=4'b0101 -> subsequent read returns 0x11BB33DD.
- Out of range: read addr 16, then write addr 0xFFFF -> two ERR_O pulses at the required latency, no ACK_O, RAM addr 0 unchanged.
- Pipelining and abort: 4 back-to-back reads of addr 0..3 -> 4 consecutive ACK cycles in order. Then issue 2 reads and drop CYC_I the cycle after the second -> zero responses.
- Wait states (WaitStates=2, Latency=1): hold STB_I for 3 requests -> STALL_O pattern 0,1,1,0,1,1,0; acceptances at cycles 0, 3, 6; each ACK one cycle after its acceptance.
